// File: rtl/key_event_ctrl_pkg.sv
// rtl/key_event_ctrl_pkg.sv - shared key FSM states, event codes and timing helper
package sdram_top_pkg;

   localparam logic [1:0] DISARMED = 2'd0;
   localparam logic [1:0] IDLE     = 2'd1;
   localparam logic [1:0] PRESSED  = 2'd2;
   localparam logic [1:0] HELD     = 2'd3;

   typedef enum logic [1:0] {
      EVT_NONE  = 2'd0,
      EVT_SHORT = 2'd1,
      EVT_LONG  = 2'd2
   } evt_t;

   // 64-bit intermediate keeps LONG_MS * 1e6 from wrapping for multi-second thresholds
   function automatic int unsigned ms_to_cycles(input int unsigned ms, input int unsigned clk_cyc_ns);
      return 32'((64'(ms) * 64'd1_000_000) / 64'(clk_cyc_ns));
   endfunction

endpackage

// File: rtl/key_event_ctrl_classifier.sv
// rtl/key_event_ctrl_classifier.sv - press edge detect, press FSM and hold counter
module key_press_classifier
   import sdram_top_pkg::*;
#(
   parameter int unsigned LONG_CNT = 100_000_000,
   parameter logic        KEY_ACT  = 1'b0
) (
   input  logic       sysclk,
   input  logic       sysrst,
   input  logic       key_in,
   output logic [1:0] evt,
   output logic [1:0] state
);

   localparam int unsigned CNT_W = $clog2(LONG_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LONG_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CNT - 1);

   logic             key_dly_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       evt_q, evt_d;
   logic             press_edge, release_edge;

   assign press_edge   = (key_dly_q != KEY_ACT) && (key_in == KEY_ACT);
   assign release_edge = (key_dly_q == KEY_ACT) && (key_in != KEY_ACT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      evt_d   = EVT_NONE;
      case (state_q)
         DISARMED: if (key_in != KEY_ACT) state_d = IDLE;
         IDLE: begin
            if (press_edge) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end
         end
         PRESSED: begin
            if (release_edge) begin
               evt_d   = EVT_SHORT;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // Long press fires while still held; counter parks at the threshold
               cnt_d   = CNT_MAX;
               evt_d   = EVT_LONG;
               state_d = HELD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD:    if (release_edge) state_d = IDLE;
         default: state_d = DISARMED;
      endcase
   end

   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         key_dly_q <= ~KEY_ACT;
         state_q   <= DISARMED;
         cnt_q     <= '0;
         evt_q     <= EVT_NONE;
      end else begin
         key_dly_q <= key_in;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         evt_q     <= evt_d;
      end
   end

   assign evt   = evt_q;
   assign state = state_q;

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - turns classified key presses into write/read test requests
module key_event_ctrl
   import sdram_top_pkg::*;
#(
   parameter int unsigned CLK_CYC = 10,
   parameter int unsigned LONG_MS = 1000,
   parameter logic        KEY_ACT = 1'b0,
   parameter int unsigned PAT_W   = 8
) (
   input  logic             sysclk,
   input  logic             sysrst,
   input  logic             key_in,
   output logic             wr_req,
   output logic             rd_req,
   input  logic             req_ack,
   output logic [PAT_W-1:0] pattern,
   output logic             evt_drop,
   output logic [1:0]       key_state
);

   localparam int unsigned LONG_CNT = ms_to_cycles(LONG_MS, CLK_CYC);

   logic [1:0]       evt;
   logic             wr_q, wr_d;
   logic             rd_q, rd_d;
   logic             drop_q, drop_d;
   logic [PAT_W-1:0] pat_q, pat_d;

   key_press_classifier #(
      .LONG_CNT (LONG_CNT),
      .KEY_ACT  (KEY_ACT)
   ) u_classifier (
      .sysclk (sysclk),
      .sysrst (sysrst),
      .key_in (key_in),
      .evt    (evt),
      .state  (key_state)
   );

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      pat_d  = pat_q;
      drop_d = 1'b0;
      if (req_ack && wr_q) begin
         wr_d  = 1'b0;
         pat_d = pat_q + 1'b1;
      end
      if (req_ack && rd_q) rd_d = 1'b0;
      // Pending is judged on the pre-ack state, so an event meeting an ack is lost
      if (evt != EVT_NONE) begin
         if (wr_q || rd_q)        drop_d = 1'b1;
         else if (evt == EVT_SHORT) wr_d = 1'b1;
         else                     rd_d   = 1'b1;
      end
   end

   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         drop_q <= 1'b0;
         pat_q  <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         drop_q <= drop_d;
         pat_q  <= pat_d;
      end
   end

   assign wr_req   = wr_q;
   assign rd_req   = rd_q;
   assign evt_drop = drop_q;
   assign pattern  = pat_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - bench for key_event_ctrl with LONG_CNT shrunk to 20
module tb_key_event_ctrl;

   localparam int LONG_CNT = 20;

   logic       sysclk = 1'b0;
   logic       sysrst = 1'b1;
   logic       key_in = 1'b1;
   logic       req_ack = 1'b0;
   logic       wr_req, rd_req, evt_drop;
   logic [7:0] pattern;
   logic [1:0] key_state;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state: key samples since reset plus request bookkeeping
   bit hist[$];
   bit m_wr, m_rd, m_drop;
   int m_pat, m_state, m_ev_pend;

   typedef struct {
      bit k; bit a; bit wr; bit rd; bit drop; int st; int pat;
   } vec_t;
   vec_t tbl[12];

   key_event_ctrl #(
      .CLK_CYC (50000),
      .LONG_MS (1),
      .KEY_ACT (1'b0),
      .PAT_W   (8)
   ) dut (
      .sysclk    (sysclk),
      .sysrst    (sysrst),
      .key_in    (key_in),
      .wr_req    (wr_req),
      .rd_req    (rd_req),
      .req_ack   (req_ack),
      .pattern   (pattern),
      .evt_drop  (evt_drop),
      .key_state (key_state)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      hist.delete();
      m_wr = 0; m_rd = 0; m_drop = 0;
      m_pat = 0; m_state = 0; m_ev_pend = 0;
   endfunction

   // Classification from run lengths of pressed (0) samples; a run counts only
   // if some released sample precedes it since reset.
   function automatic void model_edge(input bit k, input bit a);
      int n, i, lc, lp, ev;
      bit vc, vp, pend;
      hist.push_back(k);
      n = hist.size();
      lc = 0; i = n - 1;
      while (i >= 0 && hist[i] == 1'b0) begin lc++; i--; end
      vc = (i >= 0);
      lp = 0; vp = 0;
      if (k) begin
         i = n - 2;
         while (i >= 0 && hist[i] == 1'b0) begin lp++; i--; end
         vp = (i >= 0);
      end
      if (k)        m_state = 1;
      else if (!vc) m_state = 0;
      else          m_state = (lc <= LONG_CNT) ? 2 : 3;
      ev = 0;
      if (k && vp && lp >= 1 && lp <= LONG_CNT) ev = 1;
      if (!k && vc && lc == LONG_CNT + 1)        ev = 2;
      pend = m_wr | m_rd;
      m_drop = 0;
      if (a && m_wr) begin m_wr = 0; m_pat = (m_pat + 1) % 256; end
      if (a && m_rd) m_rd = 0;
      if (m_ev_pend != 0) begin
         if (pend)                m_drop = 1;
         else if (m_ev_pend == 1) m_wr = 1;
         else                     m_rd = 1;
      end
      m_ev_pend = ev;
   endfunction

   task automatic tick(input bit k, input bit a);
      key_in  = k;
      req_ack = a;
      @(posedge sysclk);
      model_edge(k, a);
      #1;
      chk("wr_req",    int'(wr_req),    int'(m_wr));
      chk("rd_req",    int'(rd_req),    int'(m_rd));
      chk("evt_drop",  int'(evt_drop),  int'(m_drop));
      chk("pattern",   int'(pattern),   m_pat);
      chk("key_state", int'(key_state), m_state);
   endtask

   task automatic do_reset(input bit k);
      key_in  = k;
      req_ack = 1'b0;
      sysrst  = 1'b1;
      #1;
      chk("rst_wr_req",    int'(wr_req),    0);
      chk("rst_rd_req",    int'(rd_req),    0);
      chk("rst_evt_drop",  int'(evt_drop),  0);
      chk("rst_pattern",   int'(pattern),   0);
      chk("rst_key_state", int'(key_state), 0);
      repeat (2) @(posedge sysclk);
      #1;
      sysrst = 1'b0;
      model_reset();
   endtask

   task automatic short_press(input int len, input bit ack_after);
      repeat (len) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      if (ack_after) tick(1'b1, 1'b1);
   endtask

   initial begin
      int rises, rise_at;
      bit prev_rd;
      int run_left;
      bit lvl;

      // Short press, ack three cycles after release
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};

      do_reset(1'b1);
      for (int i = 0; i < 12; i++) begin
         tick(tbl[i].k, tbl[i].a);
         chk($sformatf("tbl%0d_wr", i),    int'(wr_req),    int'(tbl[i].wr));
         chk($sformatf("tbl%0d_rd", i),    int'(rd_req),    int'(tbl[i].rd));
         chk($sformatf("tbl%0d_drop", i),  int'(evt_drop),  int'(tbl[i].drop));
         chk($sformatf("tbl%0d_state", i), int'(key_state), tbl[i].st);
         chk($sformatf("tbl%0d_pat", i),   int'(pattern),   tbl[i].pat);
      end

      // Key held through reset release stays disarmed
      do_reset(1'b0);
      repeat (5) tick(1'b0, 1'b0);
      chk("held_thru_rst_state", int'(key_state), 0);
      chk("held_thru_rst_req",   int'(wr_req | rd_req), 0);
      tick(1'b1, 1'b0);
      chk("armed_state", int'(key_state), 1);

      // Long hold: a single rd_req, raised while still held
      rises = 0; rise_at = -1; prev_rd = 1'b0;
      for (int t = 1; t <= 30; t++) begin
         tick(1'b0, 1'b0);
         if (rd_req && !prev_rd) begin rises++; rise_at = t; end
         prev_rd = rd_req;
      end
      chk("long_rise_cycle", rise_at, LONG_CNT + 2);
      chk("long_rise_count", rises, 1);
      chk("long_held_state", int'(key_state), 3);
      tick(1'b1, 1'b0);
      chk("long_release_state", int'(key_state), 1);

      // Short press classified in the same cycle the pending rd_req is acked
      repeat (3) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      chk("ack_collide_rd",   int'(rd_req),   0);
      chk("ack_collide_drop", int'(evt_drop), 1);
      chk("ack_collide_wr",   int'(wr_req),   0);
      tick(1'b1, 1'b0);
      chk("ack_collide_drop_end", int'(evt_drop), 0);

      // Second short press while wr_req pending is dropped
      do_reset(1'b1);
      tick(1'b1, 1'b0);
      short_press(4, 1'b0);
      short_press(3, 1'b0);
      chk("drop_pulse", int'(evt_drop), 1);
      chk("drop_wr",    int'(wr_req),   1);
      chk("drop_pat",   int'(pattern),  0);
      tick(1'b1, 1'b0);
      chk("drop_one_cycle", int'(evt_drop), 0);
      tick(1'b1, 1'b1);

      // Reset while wr_req is pending with pattern 5
      for (int p = 0; p < 4; p++) short_press(2, 1'b1);
      short_press(2, 1'b0);
      chk("pre_rst_wr",  int'(wr_req),  1);
      chk("pre_rst_pat", int'(pattern), 5);
      do_reset(1'b1);

      // Random key runs and ack pulses against the model
      run_left = 0; lvl = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (run_left == 0) begin
            lvl = ~lvl;
            run_left = lvl ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 28));
         end
         tick(lvl, $urandom_range(0, 4) == 0);
         run_left--;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
